// File: rtl/barrel_shift_reg.sv
// Registered barrel shifter: rotate, logical or arithmetic shift in either
// direction, built from log2(WIDTH) mux stages and captured on en.
module barrel_shift_reg #(
  parameter int WIDTH   = 4,
  parameter int SHIFT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHIFT_W-1:0] shift,
  input  logic               dire,
  input  logic [1:0]         mode,
  output logic [WIDTH-1:0]   data_out,
  output logic               out_valid
);

  typedef logic [WIDTH-1:0] word_t;

  logic  rotate_s;
  logic  arith_s;
  logic  fill_s;
  word_t result_s;

  // One mux stage: move every bit by step positions when sel is set.
  // Bits wrapping past either end come from the other end on rotate,
  // otherwise they take the fill value.
  function automatic word_t shift_stage(
    input word_t cur,
    input int    step,
    input logic  sel,
    input logic  right,
    input logic  rotate,
    input logic  fill
  );
    word_t nxt;
    nxt = cur;
    for (int i = 0; i < WIDTH; i++) begin
      if (!sel) begin
        nxt[i] = cur[i];
      end else if (right) begin
        if (rotate || ((i + step) < WIDTH)) begin
          nxt[i] = cur[(i + step) % WIDTH];
        end else begin
          nxt[i] = fill;
        end
      end else begin
        if (rotate || (i >= step)) begin
          nxt[i] = cur[(i - step + WIDTH) % WIDTH];
        end else begin
          nxt[i] = fill;
        end
      end
    end
    return nxt;
  endfunction

  // Decode the operating mode and choose the fill bit for vacated positions.
  always_comb begin
    rotate_s = 1'b0;
    arith_s  = 1'b0;
    case (mode)
      2'b00:   rotate_s = 1'b1;
      2'b01:   rotate_s = 1'b0;
      2'b10:   arith_s  = 1'b1;
      2'b11:   rotate_s = 1'b1;
      default: rotate_s = 1'b1;
    endcase
    // Sign fill only applies to right shifts; arithmetic left is logical left.
    if (arith_s && dire) begin
      fill_s = data_in[WIDTH-1];
    end else begin
      fill_s = 1'b0;
    end
  end

  // Cascade of stages: stage k conditionally shifts by 2^k.
  always_comb begin
    word_t acc;
    acc = data_in;
    for (int k = 0; k < SHIFT_W; k++) begin
      acc = shift_stage(acc, 1 << k, shift[k], dire, rotate_s, fill_s);
    end
    result_s = acc;
  end

  // Output register: capture on en, otherwise hold data and drop valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out  <= '0;
      out_valid <= 1'b0;
    end else if (en) begin
      data_out  <= result_s;
      out_valid <= 1'b1;
    end else begin
      data_out  <= data_out;
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_barrel_shift_reg.sv
// Directed and random checks of barrel_shift_reg against a per-bit
// reference model, with expected results queued as a scoreboard.
module tb_barrel_shift_reg;
  localparam int W  = 4;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [W-1:0]  data_in;
  logic [SW-1:0] shift;
  logic          dire;
  logic [1:0]    mode;
  logic [W-1:0]  data_out;
  logic          out_valid;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [W-1:0] data;
    logic         valid;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] held = '0;

  always #5 clk = ~clk;

  barrel_shift_reg #(.WIDTH(W), .SHIFT_W(SW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .data_in   (data_in),
    .shift     (shift),
    .dire      (dire),
    .mode      (mode),
    .data_out  (data_out),
    .out_valid (out_valid)
  );

  function automatic logic [W-1:0] model(input logic [W-1:0] d, input logic [SW-1:0] s,
                                         input logic dr, input logic [1:0] m);
    logic [W-1:0]        r;
    logic signed [W-1:0] sd;
    int                  n;
    n  = int'(s);
    sd = d;
    r  = '0;
    if (m == 2'b01) begin
      r = dr ? (d >> n) : (d << n);
    end else if (m == 2'b10) begin
      r = dr ? W'(sd >>> n) : (d << n);
    end else begin
      for (int i = 0; i < W; i++)
        r[i] = dr ? d[(i + n) % W] : d[(i - n + W) % W];
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [W-1:0] exp_d, input logic exp_v);
    checks++;
    assert (data_out === exp_d) else begin
      errors++;
      $error("FAIL %s data_out: got %b want %b", tag, data_out, exp_d);
    end
    checks++;
    assert (out_valid === exp_v) else begin
      errors++;
      $error("FAIL %s out_valid: got %b want %b", tag, out_valid, exp_v);
    end
  endtask

  // Drive one cycle of stimulus, queue its expected result, compare after the edge.
  task automatic step(input string tag, input logic e, input logic [W-1:0] d,
                      input logic [SW-1:0] s, input logic dr, input logic [1:0] m);
    exp_t x;
    en = e; data_in = d; shift = s; dire = dr; mode = m;
    if (e) begin
      held    = model(d, s, dr, m);
      x.valid = 1'b1;
    end else begin
      x.valid = 1'b0;
    end
    x.data = held;
    sb.push_back(x);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL %s scoreboard empty", tag);
    end else begin
      x = sb.pop_front();
      check(tag, x.data, x.valid);
    end
  endtask

  initial begin
    rst_n = 1'b1; en = 1'b0; data_in = '0; shift = '0; dire = 1'b0; mode = 2'b00;
    #1 rst_n = 1'b0;
    #1 check("reset_async", 4'b0000, 1'b0);

    // An enabled edge while reset is held must capture nothing.
    en = 1'b1; data_in = 4'b1101; shift = 2'd1;
    @(posedge clk);
    #1 check("reset_edge", 4'b0000, 1'b0);
    rst_n = 1'b1;

    step("rotl0", 1'b1, 4'b1101, 2'd0, 1'b0, 2'b00);
    step("rotl1", 1'b1, 4'b1101, 2'd1, 1'b0, 2'b00);
    step("rotl2", 1'b1, 4'b1101, 2'd2, 1'b0, 2'b00);
    step("rotl3", 1'b1, 4'b1101, 2'd3, 1'b0, 2'b00);
    check("rotl3_const", 4'b1110, 1'b1);
    step("rotr1", 1'b1, 4'b1101, 2'd1, 1'b1, 2'b00);
    step("rotr2", 1'b1, 4'b1101, 2'd2, 1'b1, 2'b00);
    step("rotr3", 1'b1, 4'b1101, 2'd3, 1'b1, 2'b00);
    check("rotr3_const", 4'b1011, 1'b1);
    step("lsl1", 1'b1, 4'b1101, 2'd1, 1'b0, 2'b01);
    check("lsl1_const", 4'b1010, 1'b1);
    step("lsr1", 1'b1, 4'b1101, 2'd1, 1'b1, 2'b01);
    step("lsr3", 1'b1, 4'b1101, 2'd3, 1'b1, 2'b01);
    check("lsr3_const", 4'b0001, 1'b1);
    step("asr1", 1'b1, 4'b1101, 2'd1, 1'b1, 2'b10);
    check("asr1_const", 4'b1110, 1'b1);
    step("asr3", 1'b1, 4'b1101, 2'd3, 1'b1, 2'b10);
    check("asr3_const", 4'b1111, 1'b1);
    step("asl2", 1'b1, 4'b1101, 2'd2, 1'b0, 2'b10);
    check("asl2_const", 4'b0100, 1'b1);
    step("asr_pos", 1'b1, 4'b0110, 2'd1, 1'b1, 2'b10);
    step("m11_l1", 1'b1, 4'b1101, 2'd1, 1'b0, 2'b11);
    step("m11_r3", 1'b1, 4'b1101, 2'd3, 1'b1, 2'b11);
    step("lsr0", 1'b1, 4'b1001, 2'd0, 1'b1, 2'b01);
    step("asr0", 1'b1, 4'b1001, 2'd0, 1'b1, 2'b10);

    // Hold: capture 1011, then idle while data_in and controls wander.
    step("cap1011", 1'b1, 4'b1011, 2'd0, 1'b0, 2'b00);
    step("hold1", 1'b0, 4'b0100, 2'd1, 1'b1, 2'b01);
    step("hold2", 1'b0, 4'b1111, 2'd2, 1'b0, 2'b10);
    step("hold3", 1'b0, 4'b0000, 2'd3, 1'b1, 2'b00);
    check("hold_const", 4'b1011, 1'b0);

    // Reset pulse between edges clears the output at once.
    #2 rst_n = 1'b0;
    #1 check("reset_pulse", 4'b0000, 1'b0);
    held = '0;
    sb.delete();
    #1 rst_n = 1'b1;
    step("post_idle", 1'b0, 4'b1101, 2'd1, 1'b0, 2'b00);
    step("post_rst", 1'b1, 4'b1101, 2'd1, 1'b1, 2'b00);
    check("post_rst_const", 4'b1110, 1'b1);

    // Random back-to-back traffic with occasional idle cycles.
    for (int n = 0; n < 60; n++) begin
      step("random", ($urandom_range(3, 0) != 0), W'($urandom_range(15, 0)),
           SW'($urandom_range(3, 0)), 1'($urandom_range(1, 0)), 2'($urandom_range(3, 0)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/barrel_shift_reg.md
BARREL_SHIFT_REG -- requirements
Module: barrel_shift_reg

Interface
REQ-001 The block SHALL have exactly one clock and an asynchronous, active-low reset.
REQ-002 Parameter: WIDTH, 4, data path width in bits (>= 2, power of two).
REQ-003 Parameter: SHIFT_W, $clog2(WIDTH), width of the shift amount.
REQ-004 Port: clk  input  1  rising-edge clock.
REQ-005 Port: rst_n  input  1  asynchronous active-low reset.
REQ-006 Port: en  input  1  capture enable; the operation is registered only when en=1.
REQ-007 Port: data_in  input  WIDTH  operand to shift.
REQ-008 Port: shift  input  SHIFT_W  shift amount, 0..WIDTH-1.
REQ-009 Port: dire  input  1  direction; 0 = left (towards MSB), 1 = right (towards LSB).
REQ-010 Port: mode  input  2  00 = rotate, 01 = logical shift, 10 = arithmetic shift, 11 = rotate.
REQ-011 Port: data_out  output  WIDTH  registered shift result.
REQ-012 Port: out_valid  output  1  high for one cycle when data_out holds a new result.

Function
REQ-013 The result SHALL be computed combinationally from data_in, shift, dire and mode, using log2(WIDTH) mux stages (stage k conditionally shifts by 2^k).
REQ-014 Rotate left SHALL give data_out[i] = data_in[(i - shift) mod WIDTH]; rotate right SHALL give data_out[i] = data_in[(i + shift) mod WIDTH].
REQ-015 Logical shift SHALL fill vacated bit positions with 0 in either direction.
REQ-016 Arithmetic right shift SHALL fill vacated MSB positions with data_in[WIDTH-1]; arithmetic left shift SHALL equal logical left shift.
REQ-017 shift = 0 SHALL pass data_in unchanged in every mode and direction.
REQ-018 Latency SHALL be exactly one clock: on a rising edge with en=1, data_out SHALL load the result and out_valid SHALL be 1 in the following cycle.
REQ-019 On a rising edge with en=0, data_out SHALL hold its previous value and out_valid SHALL be 0.
REQ-020 Back-to-back en=1 cycles SHALL produce one result per cycle, with no bubbles.
REQ-021 Inputs SHALL be sampled only at the rising clk edge; input changes between edges SHALL NOT affect data_out.
REQ-022 No illegal input combinations SHALL exist; mode 11 SHALL behave exactly as mode 00.

Reset
REQ-023 While rst_n=0, data_out SHALL be all zeros and out_valid SHALL be 0, immediately and independent of clk.
REQ-024 Reset asserted mid-operation SHALL discard any captured result; the first result after release SHALL come from the first en=1 edge with rst_n=1.
REQ-025 Deassertion of rst_n SHALL take effect at the next rising edge; no operation SHALL be captured on the edge where rst_n is low.

Verification
REQ-026 Rotate left, data_in=1101, mode=00, dire=0, shift=0/1/2/3, en=1 -> data_out one cycle later = 1101/1011/0111/1110, out_valid=1 each cycle.
REQ-027 Rotate right, data_in=1101, mode=00, dire=1, shift=1/2/3 -> data_out = 1110/0111/1011.
REQ-028 Logical shift, data_in=1101, mode=01: left by 1 -> 1010; right by 1 -> 0110; right by 3 -> 0001.
REQ-029 Arithmetic shift, data_in=1101, mode=10: right by 1 -> 1110; right by 3 -> 1111; left by 2 -> 0100.
REQ-030 Hold: capture 1011, then en=0 for 3 cycles while data_in toggles -> data_out stays 1011 and out_valid=0.
REQ-031 Reset: pulse rst_n low between clock edges while data_out=1011 -> data_out=0000 and out_valid=0 at once; the next en=1 edge after release gives a correct new result.
